// File: rtl/micro_pkg.sv
// Shared microcontroller package: jump/call opcode constants and the
// sequencer FSM state type, also imported by unidad_control.
package micro_pkg;

  localparam logic [5:0] OP_J    = 6'b100000;
  localparam logic [5:0] OP_JZ   = 6'b100001;
  localparam logic [5:0] OP_JNZ  = 6'b100010;
  localparam logic [5:0] OP_CALL = 6'b100011;
  localparam logic [5:0] OP_RET  = 6'b100100;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } estado_t;

endpackage

// File: rtl/pila_retorno.sv
// Return-address LIFO. Only the stack pointer is reset; the storage array is
// plain data. Push on full and pop on empty are ignored (the caller flags them).
module pila_retorno #(
  parameter int W     = 10,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         vacia,
  output logic         llena
);

  localparam int SP_W  = $clog2(DEPTH + 1);
  localparam int IDX_W = $clog2(DEPTH);

  logic [W-1:0]    mem [DEPTH];
  logic [SP_W-1:0] sp;
  logic [SP_W-1:0] sp_dec;

  assign sp_dec = sp - SP_W'(1);
  assign vacia  = (sp == '0);
  assign llena  = (sp == SP_W'(DEPTH));
  // Top of stack sits one below the pointer; valid whenever vacia is 0.
  assign dout   = mem[sp_dec[IDX_W-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      sp <= '0;
    end else if (push && !llena) begin
      sp <= sp + SP_W'(1);
    end else if (pop && !vacia) begin
      sp <= sp_dec;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !llena) begin
      mem[sp[IDX_W-1:0]] <= din;
    end
  end

endmodule

// File: rtl/secuenciador_pc.sv
// Program-counter sequencer: increment, jumps, conditional jumps and CALL/RET.
// Define SECUENCIADOR_HALT_EN to halt on stack overflow/underflow.
module secuenciador_pc
  import micro_pkg::*;
#(
  parameter int PC_W        = 10,
  parameter int STACK_DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [5:0]      opcode,
  input  logic            zero,
  input  logic [PC_W-1:0] dir_salto,
  output logic [PC_W-1:0] pc,
  output logic            s_inc,
  output logic            pila_vacia,
  output logic            pila_llena,
  output logic            error_pila,
  output logic            parado
);

  estado_t         state;
  estado_t         state_next;
  logic [PC_W-1:0] pc_inc;
  logic [PC_W-1:0] pc_next;
  logic [PC_W-1:0] ret_addr;
  logic            push;
  logic            pop;
  logic            err_set;

  assign pc_inc = pc + PC_W'(1);

  pila_retorno #(
    .W     (PC_W),
    .DEPTH (STACK_DEPTH)
  ) u_pila (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (pc_inc),
    .dout  (ret_addr),
    .vacia (pila_vacia),
    .llena (pila_llena)
  );

  always_comb begin
    pc_next    = pc;
    s_inc      = 1'b0;
    push       = 1'b0;
    pop        = 1'b0;
    err_set    = 1'b0;
    state_next = state;
    if (state == ST_RUN) begin
      pc_next = pc_inc;
      s_inc   = 1'b1;
      case (opcode)
        OP_J: begin
          pc_next = dir_salto;
          s_inc   = 1'b0;
        end
        OP_JZ: begin
          if (zero) begin
            pc_next = dir_salto;
            s_inc   = 1'b0;
          end
        end
        OP_JNZ: begin
          if (!zero) begin
            pc_next = dir_salto;
            s_inc   = 1'b0;
          end
        end
        OP_CALL: begin
          s_inc = 1'b0;
          if (pila_llena) begin
            err_set = 1'b1;
`ifdef SECUENCIADOR_HALT_EN
            pc_next    = pc;
            state_next = ST_HALT;
`else
            pc_next = dir_salto;
`endif
          end else begin
            push    = 1'b1;
            pc_next = dir_salto;
          end
        end
        OP_RET: begin
          if (pila_vacia) begin
            err_set = 1'b1;
`ifdef SECUENCIADOR_HALT_EN
            pc_next    = pc;
            s_inc      = 1'b0;
            state_next = ST_HALT;
`endif
          end else begin
            pop     = 1'b1;
            pc_next = ret_addr;
            s_inc   = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_RUN;
      pc         <= '0;
      error_pila <= 1'b0;
    end else begin
      state <= state_next;
      pc    <= pc_next;
      if (err_set) begin
        error_pila <= 1'b1;
      end
    end
  end

`ifdef SECUENCIADOR_HALT_EN
  assign parado = (state == ST_HALT);
`else
  assign parado = 1'b0;
`endif

endmodule

// File: tb/tb_secuenciador_pc.sv
// Self-checking bench for secuenciador_pc (default build, no HALT): directed
// vector table, a hand-written wrap-around CALL/RET sequence, then random opcodes.
module tb_secuenciador_pc;
  import micro_pkg::*;

  localparam int PC_W  = 10;
  localparam int DEPTH = 4;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [5:0]      opcode = '0;
  logic            zero = 1'b0;
  logic [PC_W-1:0] dir_salto = '0;
  logic [PC_W-1:0] pc;
  logic            s_inc;
  logic            pila_vacia;
  logic            pila_llena;
  logic            error_pila;
  logic            parado;

  int checks = 0;
  int errors = 0;

  secuenciador_pc #(.PC_W(PC_W), .STACK_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .opcode     (opcode),
    .zero       (zero),
    .dir_salto  (dir_salto),
    .pc         (pc),
    .s_inc      (s_inc),
    .pila_vacia (pila_vacia),
    .pila_llena (pila_llena),
    .error_pila (error_pila),
    .parado     (parado)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit              rst;
    logic [5:0]      op;
    bit              z;
    logic [PC_W-1:0] d;
    bit              s;
    logic [PC_W-1:0] epc;
    bit              vac;
    bit              lle;
    bit              err;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One cycle: drive at negedge, check combinational s_inc, then registered state.
  task automatic step(input bit r, input logic [5:0] op, input bit z,
                      input logic [PC_W-1:0] d, input bit es, input logic [PC_W-1:0] epc,
                      input bit ev, input bit el, input bit ee, input string tag);
    @(negedge clk);
    reset = r; opcode = op; zero = z; dir_salto = d;
    #1;
    if (!r) check({tag, " s_inc"}, 32'(s_inc), 32'(es));
    @(posedge clk);
    #1;
    check({tag, " pc"}, 32'(pc), 32'(epc));
    check({tag, " pila_vacia"}, 32'(pila_vacia), 32'(ev));
    check({tag, " pila_llena"}, 32'(pila_llena), 32'(el));
    check({tag, " error_pila"}, 32'(error_pila), 32'(ee));
    check({tag, " parado"}, 32'(parado), 32'(0));
  endtask

  // Behavioural reference model
  int unsigned m_pc;
  int unsigned m_stk[$];
  bit          m_err;

  task automatic model(input bit r, input logic [5:0] op, input bit z,
                       input logic [PC_W-1:0] d, output bit es);
    int unsigned nxt;
    nxt = (m_pc + 1) % (1 << PC_W);
    es  = 1'b1;
    if (r) begin
      m_pc = 0; m_stk.delete(); m_err = 1'b0;
      return;
    end
    if (op == OP_J || (op == OP_JZ && z) || (op == OP_JNZ && !z)) begin
      es = 1'b0; m_pc = d;
    end else if (op == OP_CALL) begin
      es = 1'b0;
      if (m_stk.size() == DEPTH) m_err = 1'b1;
      else m_stk.push_back(nxt);
      m_pc = d;
    end else if (op == OP_RET && m_stk.size() != 0) begin
      es = 1'b0; m_pc = m_stk.pop_back();
    end else begin
      if (op == OP_RET) m_err = 1'b1;
      m_pc = nxt;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    bit es;
    logic [5:0] op;
    bit z, r;
    logic [PC_W-1:0] d;

    //        rst op       z  d       s  pc      vac lle err
    tbl.push_back('{1, 6'h00,  0, 10'h000, 0, 10'h000, 1, 0, 0});
    for (int i = 1; i <= 5; i++)
      tbl.push_back('{0, 6'h00, 0, 10'h000, 1, PC_W'(i), 1, 0, 0});
    tbl.push_back('{0, OP_JZ,   1, 10'h040, 0, 10'h040, 1, 0, 0});
    tbl.push_back('{0, OP_JZ,   0, 10'h040, 1, 10'h041, 1, 0, 0});
    tbl.push_back('{0, OP_JNZ,  0, 10'h010, 0, 10'h010, 1, 0, 0});
    tbl.push_back('{0, OP_JNZ,  1, 10'h040, 1, 10'h011, 1, 0, 0});
    tbl.push_back('{0, OP_J,    0, 10'h010, 0, 10'h010, 1, 0, 0});
    tbl.push_back('{0, OP_CALL, 0, 10'h100, 0, 10'h100, 0, 0, 0});
    tbl.push_back('{0, OP_CALL, 0, 10'h200, 0, 10'h200, 0, 0, 0});
    tbl.push_back('{0, OP_RET,  0, 10'h000, 0, 10'h101, 0, 0, 0});
    tbl.push_back('{0, OP_RET,  0, 10'h000, 0, 10'h011, 1, 0, 0});
    tbl.push_back('{0, OP_CALL, 0, 10'h020, 0, 10'h020, 0, 0, 0});
    tbl.push_back('{0, OP_CALL, 0, 10'h030, 0, 10'h030, 0, 0, 0});
    tbl.push_back('{0, OP_CALL, 0, 10'h040, 0, 10'h040, 0, 0, 0});
    tbl.push_back('{0, OP_CALL, 0, 10'h050, 0, 10'h050, 0, 1, 0});
    tbl.push_back('{0, OP_CALL, 1, 10'h060, 0, 10'h060, 0, 1, 1});
    tbl.push_back('{0, OP_RET,  0, 10'h000, 0, 10'h041, 0, 0, 1});
    tbl.push_back('{0, OP_RET,  0, 10'h000, 0, 10'h031, 0, 0, 1});
    tbl.push_back('{0, OP_RET,  0, 10'h000, 0, 10'h021, 0, 0, 1});
    tbl.push_back('{0, OP_RET,  0, 10'h000, 0, 10'h012, 1, 0, 1});
    tbl.push_back('{0, OP_RET,  0, 10'h000, 1, 10'h013, 1, 0, 1});
    tbl.push_back('{1, OP_CALL, 0, 10'h155, 0, 10'h000, 1, 0, 0});
    tbl.push_back('{0, OP_RET,  0, 10'h000, 1, 10'h001, 1, 0, 1});
    tbl.push_back('{1, OP_RET,  0, 10'h000, 0, 10'h000, 1, 0, 0});
    tbl.push_back('{0, OP_J,    0, 10'h3FF, 0, 10'h3FF, 1, 0, 0});
    tbl.push_back('{0, 6'h00,   0, 10'h000, 1, 10'h000, 1, 0, 0});
    tbl.push_back('{0, 6'b100101, 1, 10'h2AA, 1, 10'h001, 1, 0, 0});

    foreach (tbl[i])
      step(tbl[i].rst, tbl[i].op, tbl[i].z, tbl[i].d, tbl[i].s, tbl[i].epc,
           tbl[i].vac, tbl[i].lle, tbl[i].err, $sformatf("vec%0d", i));

    // CALL from the last address pushes a wrapped return address of 0.
    step(0, OP_J,    0, 10'h3FF, 0, 10'h3FF, 1, 0, 0, "wrap_j");
    step(0, OP_CALL, 0, 10'h005, 0, 10'h005, 0, 0, 0, "wrap_call");
    step(0, OP_RET,  0, 10'h000, 0, 10'h000, 1, 0, 0, "wrap_ret");

    model(1, 6'h00, 0, '0, es);
    step(1, 6'h00, 0, '0, 0, 10'h000, 1, 0, 0, "rand_rst");
    for (int n = 0; n < 400; n++) begin
      r = ($urandom_range(0, 39) == 0);
      z = 1'($urandom_range(0, 1));
      d = PC_W'($urandom);
      case ($urandom_range(0, 9))
        0, 1:    op = 6'($urandom);
        2:       op = OP_J;
        3:       op = OP_JZ;
        4:       op = OP_JNZ;
        5, 6:    op = OP_CALL;
        7, 8:    op = OP_RET;
        default: op = 6'h00;
      endcase
      model(r, op, z, d, es);
      step(r, op, z, d, es, PC_W'(m_pc), m_stk.size() == 0, m_stk.size() == DEPTH,
           m_err, $sformatf("rand%0d", n));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/secuenciador_pc.md
# secuenciador_pc

Program-counter sequencer for the microcontroller. It owns the PC register and decides the next fetch address every cycle: sequential increment, unconditional jump, conditional jump on the datapath `zero` flag, and subroutine call/return through a hardware return-address stack. It sits between instruction memory and the datapath, next to `unidad_control`, and takes over all next-PC selection.

## Interface
Parameters:
- `PC_W`, 10: PC and jump-target width.
- `STACK_DEPTH`, 4: return-stack entries, ≥2.

Ports (`clk` rising edge; `reset` synchronous, active-high):
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `opcode`  in  6  opcode of the instruction at the current `pc`.
- `zero`  in  1  datapath zero flag, valid in the same cycle as `opcode`.
- `dir_salto`  in  `PC_W`  jump/call target field of the current instruction.
- `pc`  out  `PC_W`  registered fetch address.
- `s_inc`  out  1  combinational; 1 when next PC = `pc`+1.
- `pila_vacia`  out  1  registered; stack empty.
- `pila_llena`  out  1  registered; stack holds `STACK_DEPTH` entries.
- `error_pila`  out  1  registered, sticky; overflow or underflow occurred.
- `parado`  out  1  registered; sequencer is in HALT.

## Operation
- States: RUN, HALT. Reset → RUN.
- RUN, by opcode (values in package):
  - `OP_J` (6'b100000): pc ← `dir_salto`.
  - `OP_JZ` (6'b100001): pc ← `dir_salto` if `zero`=1, else pc+1.
  - `OP_JNZ` (6'b100010): pc ← `dir_salto` if `zero`=0, else pc+1.
  - `OP_CALL` (6'b100011): push pc+1; pc ← `dir_salto`.
  - `OP_RET` (6'b100100): pop; pc ← popped value.
  - Any other opcode: pc ← pc+1.
- `s_inc` = 1 exactly when the RUN next-PC is pc+1. It is 0 for taken jumps, CALL and RET, and 0 in HALT.
- pc+1 wraps modulo 2^`PC_W`. Max address + 1 → 0, with no error. A pushed return address wraps the same way.
- Stack: LIFO array plus pointer `sp` of width clog2(`STACK_DEPTH`+1). `pila_vacia` = (sp==0). `pila_llena` = (sp==`STACK_DEPTH`).
- Overflow: CALL with `pila_llena`=1. Underflow: RET with `pila_vacia`=1. Either sets `error_pila`. What follows is set by Configuration.
- HALT: pc, stack and flags frozen; `parado`=1. Only `reset` leaves HALT.
- Only one opcode is presented per cycle, so push and pop are never simultaneous.

## Timing
- All state (pc, stack, sp, flags, FSM) updates on the rising `clk` edge. `s_inc` is combinational from `opcode`, `zero` and the FSM state.
- Latency: next-PC decision takes 1 cycle. The new pc is visible the cycle after the opcode is presented.
- A RET immediately after a CALL returns to the CALL's pc+1, with no bubble.
- Reset has priority over every opcode in the same cycle, including mid-CALL, mid-RET and HALT. Reset values:
  - pc=0, sp=0, FSM=RUN.
  - `pila_vacia`=1, `pila_llena`=0, `error_pila`=0, `parado`=0.
  - Stack contents are don't-care.

## Configuration
- `SECUENCIADOR_HALT_EN` defined:
  - Overflow or underflow sets `error_pila` and enters HALT the next cycle. pc keeps its value and the offending CALL/RET has no other effect.
- `SECUENCIADOR_HALT_EN` not defined (no HALT state; `parado` tied 0):
  - Overflow: jump taken, push dropped, sp unchanged.
  - Underflow: treated as a plain instruction (pc ← pc+1, `s_inc`=1).
  - `error_pila` is still set, sticky.

## Structure
- Shared package `micro_pkg`: opcode constants `OP_J`, `OP_JZ`, `OP_JNZ`, `OP_CALL`, `OP_RET`; the FSM state typedef. `unidad_control` imports the same constants.
- Sub-module `pila_retorno`: parameterised LIFO with push/pop, `vacia`/`llena`, synchronous reset of the pointer only.

## Test plan
- Reset, then 5 plain opcodes (6'b000000) → pc 0,1,2,3,4,5; `s_inc`=1 throughout; `pila_vacia`=1.
- `OP_JZ` with `dir_salto`=0x040: `zero`=1 → pc=0x040, `s_inc`=0. Repeat with `zero`=0 → pc+1. `OP_JNZ` gives the mirror results.
- CALL 0x100 at pc=0x010, CALL 0x200 at 0x100, RET, RET → pc 0x100, 0x200, 0x101, 0x011; sp 1,2,1,0.
- `STACK_DEPTH`=4, five nested CALLs:
  - Macro on: `error_pila`=1 and `parado`=1 the cycle after the 5th CALL; pc frozen.
  - Macro off: pc=target, sp=4, `error_pila`=1.
- RET out of reset (empty stack):
  - Macro on: HALT.
  - Macro off: pc 0→1, `error_pila`=1.
  - Then assert `reset` → all outputs at reset values.
- pc at 0x3FF (`PC_W`=10) with a plain opcode → pc=0x000, `error_pila`=0. CALL at 0x3FF then RET → returns to 0x000.
